nibble_serializer: RTL

Parallel-to-serial feeder for the 4-bit right shift register (serial input `SDR`, LSB-first capture). It accepts a nibble over a valid/ready handshake and emits it one bit per clock on `SDR`, LSB first. It also produces a bit-valid strobe that the downstream register uses as its shift enable. A one-entry holding buffer lets nibbles stream back-to-back with no idle cycles between frames.

---
 rtl/serial_pkg.sv | 12 +
 rtl/nibble_hold_buf.sv | 51 +++++
 rtl/nibble_serializer.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and sizing for the nibble serializer and its holding buffer.
package serial_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CW        = $clog2(WIDTH_DEF);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_hold_buf.sv
// One-entry holding register. Parks a word while the shifter is busy.
module nibble_hold_buf
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             full_d_o
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;

    // load and drain are mutually exclusive: load needs an empty entry, drain a full one
    always_comb begin
        full_d = full_q;
        if (load_i) begin
            full_d = 1'b1;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // NOTE: payload register is not reset; full_q alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o   = data_q;
    assign full_o   = full_q;
    assign full_d_o = full_d;

endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial feeder: LSB-first bit stream with shift-enable strobe and
// a one-deep buffer so frames can run back-to-back.
module nibble_serializer
    import serial_pkg::*;
#(
    parameter int   WIDTH      = WIDTH_DEF,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clrb,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             SDR,
    output logic             sdr_en,
    output logic             frame_last,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ready_q;
    logic             busy_q;

    logic             hold_full;
    logic             hold_full_d;
    logic [WIDTH-1:0] hold_data;
    logic             hold_load;
    logic             hold_drain;
    logic             accept;
    logic             last_bit;

    assign accept   = din_valid & ready_q;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST);

    nibble_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .clrb     (clrb),
        .load_i   (hold_load),
        .drain_i  (hold_drain),
        .data_i   (din),
        .data_o   (hold_data),
        .full_o   (hold_full),
        .full_d_o (hold_full_d)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        shreg_d    = hold_data;
                        hold_drain = 1'b1;
                    end else if (accept) begin
                        shreg_d = din;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    hold_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ready/busy follow the next-state buffer flag so a full buffer is never offered
    always_ff @(posedge clk or negedge clrb) begin
        if (!clrb) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ready_q <= ~hold_full_d;
            busy_q  <= (state_d == ST_SHIFT) | hold_full_d;
        end
    end

    assign din_ready  = ready_q;
    assign busy       = busy_q;
    assign sdr_en     = (state_q == ST_SHIFT);
    assign SDR        = (state_q == ST_SHIFT) ? shreg_q[0] : IDLE_LEVEL;
    assign frame_last = last_bit;

endmodule
